// File: rtl/svc_vga_pix.sv
// VGA capture: registers hsync/vsync/RGB, locks onto the mode timing and emits a valid/ready pixel
// stream with x/y. Optional blanking colour check via `define SVC_VGA_PIX_BLANK_CHECK_EN.
module svc_vga_pix #(
  parameter int unsigned H_WIDTH     = 12,
  parameter int unsigned V_WIDTH     = 12,
  parameter int unsigned COLOR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   vga_hsync,
  input  logic                   vga_vsync,
  input  logic [COLOR_WIDTH-1:0] vga_red,
  input  logic [COLOR_WIDTH-1:0] vga_grn,
  input  logic [COLOR_WIDTH-1:0] vga_blu,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [H_WIDTH-1:0]     h_sync_start,
  input  logic [H_WIDTH-1:0]     h_sync_end,
  input  logic [H_WIDTH-1:0]     h_line_end,
  input  logic [V_WIDTH-1:0]     v_visible,
  input  logic [V_WIDTH-1:0]     v_sync_start,
  input  logic [V_WIDTH-1:0]     v_sync_end,
  input  logic [V_WIDTH-1:0]     v_frame_end,
  output logic                   m_pix_valid,
  output logic [COLOR_WIDTH-1:0] m_pix_red,
  output logic [COLOR_WIDTH-1:0] m_pix_grn,
  output logic [COLOR_WIDTH-1:0] m_pix_blu,
  output logic [H_WIDTH-1:0]     m_pix_x,
  output logic [V_WIDTH-1:0]     m_pix_y,
  input  logic                   m_pix_ready,
  output logic                   locked,
  output logic                   pix_error
);

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StAlign    = 2'd1,
    StLocked   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                   hsync_q, vsync_q, hsync_prev_q, vsync_prev_q;
  logic [COLOR_WIDTH-1:0] red_q, grn_q, blu_q;
  logic [H_WIDTH-1:0]     h_cnt, h_base, h_next;
  logic [V_WIDTH-1:0]     v_cnt, v_base, v_next;

  logic                   pix_valid_q;
  logic [COLOR_WIDTH-1:0] pix_red_q, pix_grn_q, pix_blu_q;
  logic [H_WIDTH-1:0]     pix_x_q;
  logic [V_WIDTH-1:0]     pix_y_q;
  logic                   pix_error_q;

  logic vfall, hfall, hrise;
  logic hfall_bad, hrise_bad, vfall_bad;
  logic sync_err, blank_err, emit, accept, overflow;
  logic h_vis, v_vis;

  // vsync deassert position is not checked
  logic unused_timing;
  assign unused_timing = ^v_sync_end;

  // Stage 0: input capture plus previous sync levels for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      hsync_prev_q <= 1'b1;
      vsync_prev_q <= 1'b1;
      red_q        <= '0;
      grn_q        <= '0;
      blu_q        <= '0;
    end else begin
      hsync_q      <= vga_hsync;
      vsync_q      <= vga_vsync;
      hsync_prev_q <= hsync_q;
      vsync_prev_q <= vsync_q;
      red_q        <= vga_red;
      grn_q        <= vga_grn;
      blu_q        <= vga_blu;
    end
  end

  assign vfall = vsync_prev_q & ~vsync_q;
  assign hfall = hsync_prev_q & ~hsync_q;
  assign hrise = ~hsync_prev_q & hsync_q;

  assign hfall_bad = hfall && (h_cnt != h_sync_start);
  assign hrise_bad = hrise && (h_cnt != h_sync_end);
  assign vfall_bad = vfall && ((h_cnt != '0) || (v_cnt != v_sync_start));

  // The vfall sample is by definition at (0, v_sync_start); advance from there
  always_comb begin
    h_base = h_cnt;
    v_base = v_cnt;
    if (state_q == StUnlocked && vfall) begin
      h_base = '0;
      v_base = v_sync_start;
    end
    h_next = h_base + H_WIDTH'(1);
    v_next = v_base;
    if (h_base == h_line_end) begin
      h_next = '0;
      v_next = (v_base == v_frame_end) ? '0 : v_base + V_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  always_comb begin
    state_d  = state_q;
    sync_err = 1'b0;
    unique case (state_q)
      StUnlocked: begin
        if (vfall) state_d = StAlign;
      end
      StAlign: begin
        if (hfall) begin
          if (hfall_bad) begin
            state_d  = StUnlocked;
            sync_err = 1'b1;
          end else begin
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (hfall_bad || hrise_bad || vfall_bad) begin
          state_d  = StUnlocked;
          sync_err = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StUnlocked;
    else        state_q <= state_d;
  end

  assign h_vis    = h_cnt < h_visible;
  assign v_vis    = v_cnt < v_visible;
  assign emit     = (state_q == StLocked) && h_vis && v_vis;
  assign accept   = pix_valid_q && m_pix_ready;
  assign overflow = emit && pix_valid_q && !m_pix_ready;

`ifdef SVC_VGA_PIX_BLANK_CHECK_EN
  assign blank_err = (state_q == StLocked) && !(h_vis && v_vis) &&
                     ((red_q | grn_q | blu_q) != '0);
`else
  assign blank_err = 1'b0;
`endif

  // Single-entry output register; an overflowing pixel is dropped, held data kept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid_q <= 1'b0;
      pix_red_q   <= '0;
      pix_grn_q   <= '0;
      pix_blu_q   <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_error_q <= 1'b0;
    end else begin
      pix_error_q <= sync_err | overflow | blank_err;
      if (emit && !overflow) begin
        pix_valid_q <= 1'b1;
        pix_red_q   <= red_q;
        pix_grn_q   <= grn_q;
        pix_blu_q   <= blu_q;
        pix_x_q     <= h_cnt;
        pix_y_q     <= v_cnt;
      end else if (accept) begin
        pix_valid_q <= 1'b0;
      end
    end
  end

  assign m_pix_valid = pix_valid_q;
  assign m_pix_red   = pix_red_q;
  assign m_pix_grn   = pix_grn_q;
  assign m_pix_blu   = pix_blu_q;
  assign m_pix_x     = pix_x_q;
  assign m_pix_y     = pix_y_q;
  assign locked      = (state_q == StLocked);
  assign pix_error   = pix_error_q;

endmodule

// File: tb/tb_svc_vga_pix.sv
// Directed bench for svc_vga_pix using a small 16x12 raster mode driven by an in-bench generator.
module tb_svc_vga_pix;

  localparam int HV  = 8;
  localparam int HSS = 10;
  localparam int HSE = 12;
  localparam int HLE = 15;
  localparam int VV  = 6;
  localparam int VSS = 8;
  localparam int VSE = 9;
  localparam int VFE = 11;
`ifdef SVC_VGA_PIX_BLANK_CHECK_EN
  localparam int BlankErrs = 1;
`else
  localparam int BlankErrs = 0;
`endif

  logic        clk, rst_n, vga_hsync, vga_vsync;
  logic [3:0]  vga_red, vga_grn, vga_blu;
  logic [11:0] h_visible, h_sync_start, h_sync_end, h_line_end;
  logic [11:0] v_visible, v_sync_start, v_sync_end, v_frame_end;
  logic        m_pix_valid, m_pix_ready, locked, pix_error;
  logic [3:0]  m_pix_red, m_pix_grn, m_pix_blu;
  logic [11:0] m_pix_x, m_pix_y;

  int n_checks = 0;
  int n_fail   = 0;

  int   g_h, g_v;
  bit   shift_armed, blank_armed, stall_armed;
  int   shift_line, blank_line, stall_x;
  bit   beat;
  int   bx, by;
  logic [3:0] br, bg, bb;
  logic obs_valid, obs_locked, err_seen;
  int   err_total = 0;

  svc_vga_pix dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_hsync    (vga_hsync),
    .vga_vsync    (vga_vsync),
    .vga_red      (vga_red),
    .vga_grn      (vga_grn),
    .vga_blu      (vga_blu),
    .h_visible    (h_visible),
    .h_sync_start (h_sync_start),
    .h_sync_end   (h_sync_end),
    .h_line_end   (h_line_end),
    .v_visible    (v_visible),
    .v_sync_start (v_sync_start),
    .v_sync_end   (v_sync_end),
    .v_frame_end  (v_frame_end),
    .m_pix_valid  (m_pix_valid),
    .m_pix_red    (m_pix_red),
    .m_pix_grn    (m_pix_grn),
    .m_pix_blu    (m_pix_blu),
    .m_pix_x      (m_pix_x),
    .m_pix_y      (m_pix_y),
    .m_pix_ready  (m_pix_ready),
    .locked       (locked),
    .pix_error    (pix_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive_pins();
    int hs, he;
    hs = HSS;
    he = HSE;
    if (shift_armed && g_v == shift_line) begin
      hs = HSS + 3;
      he = HSE + 3;
    end
    vga_hsync = !(g_h >= hs && g_h < he);
    vga_vsync = !(g_v >= VSS && g_v < VSE);
    if (g_h < HV && g_v < VV) begin
      vga_red = 4'(g_h);
      vga_grn = 4'(g_v);
      vga_blu = 4'h8;
    end else begin
      vga_red = 4'h0;
      vga_grn = 4'h0;
      vga_blu = 4'h0;
    end
    if (blank_armed && g_v == blank_line && g_h == 9) vga_red = 4'h1;
  endtask

  task automatic gen_step();
    if (g_h == HLE) begin
      g_h = 0;
      if (shift_armed && g_v == shift_line) shift_armed = 1'b0;
      if (blank_armed && g_v == blank_line) blank_armed = 1'b0;
      g_v = (g_v == VFE) ? 0 : g_v + 1;
    end else begin
      g_h = g_h + 1;
    end
  endtask

  // Observe outputs away from the edge, decide ready, then present the next pixel
  task automatic tick();
    @(negedge clk);
    if (stall_armed && m_pix_valid && m_pix_x == 12'(stall_x)) begin
      m_pix_ready = 1'b0;
      stall_armed = 1'b0;
    end else begin
      m_pix_ready = 1'b1;
    end
    obs_valid  = m_pix_valid;
    obs_locked = locked;
    err_seen   = pix_error;
    if (pix_error === 1'b1) err_total++;
    beat = (m_pix_valid === 1'b1) && m_pix_ready;
    bx = int'(m_pix_x);
    by = int'(m_pix_y);
    br = m_pix_red;
    bg = m_pix_grn;
    bb = m_pix_blu;
    gen_step();
    drive_pins();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if (obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", obs_valid);
    end
    n_checks++;
    if (obs_locked !== 1'b0) begin
      n_fail++; $display("FAIL reset_locked: got %b want 0", obs_locked);
    end
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_error: got %b want 0", err_seen);
    end
    n_checks++;
    if ({m_pix_x, m_pix_y} !== 24'h0) begin
      n_fail++; $display("FAIL reset_xy: got %0h/%0h want 0/0", m_pix_x, m_pix_y);
    end
    n_checks++;
    if ({m_pix_red, m_pix_grn, m_pix_blu} !== 12'h0) begin
      n_fail++; $display("FAIL reset_rgb: got %h want 000", {m_pix_red, m_pix_grn, m_pix_blu});
    end
  endtask

  task automatic test_lock();
    bit got, early;
    got = 1'b0;
    early = 1'b0;
    rst_n = 1'b1;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (beat) early = 1'b1;
      if (obs_locked === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL lock_timeout: locked never rose");
    end
    n_checks++;
    if (g_h != HSS + 2 || g_v != VSS) begin
      n_fail++; $display("FAIL lock_time: rose at gen %0d,%0d want %0d,%0d", g_h, g_v, HSS + 2, VSS);
    end
    n_checks++;
    if (early) begin
      n_fail++; $display("FAIL lock_early_beat: beat seen before lock");
    end
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (beat) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || bx != 0 || by != 0) begin
      n_fail++; $display("FAIL first_beat: got %0d,%0d (seen %0b) want 0,0", bx, by, got);
    end
    n_checks++;
    if (g_h != 2 || g_v != 0) begin
      n_fail++; $display("FAIL first_beat_time: gen %0d,%0d want 2,0", g_h, g_v);
    end
    n_checks++;
    if ({br, bg, bb} !== 12'h008) begin
      n_fail++; $display("FAIL first_beat_rgb: got %h want 008", {br, bg, bb});
    end
    n_checks++;
    if (err_total != 0) begin
      n_fail++; $display("FAIL lock_errors: got %0d want 0", err_total);
    end
  endtask

  task automatic test_full_frame();
    int nb, ex, ey, e0;
    bit got;
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (beat && bx == 0 && by == 0) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL frame_start: no 0,0 beat");
    end
    e0 = err_total;
    nb = 1;
    ex = 1;
    ey = 0;
    for (int t = 0; t < 191; t++) begin
      tick();
      if (beat) begin
        nb++;
        n_checks++;
        if (bx != ex || by != ey || br !== 4'(ex) || bg !== 4'(ey) || bb !== 4'h8) begin
          n_fail++;
          $display("FAIL frame_beat: got %0d,%0d rgb %h want %0d,%0d rgb %h",
                   bx, by, {br, bg, bb}, ex, ey, {4'(ex), 4'(ey), 4'h8});
        end
        ex++;
        if (ex == HV) begin
          ex = 0;
          ey++;
        end
      end
    end
    n_checks++;
    if (nb != HV * VV) begin
      n_fail++; $display("FAIL frame_count: got %0d want %0d", nb, HV * VV);
    end
    n_checks++;
    if (err_total != e0) begin
      n_fail++; $display("FAIL frame_errors: got %0d want 0", err_total - e0);
    end
  endtask

  task automatic test_backpressure();
    int row;
    stall_x = 3;
    stall_armed = 1'b1;
    for (int t = 0; t < 400 && stall_armed; t++) tick();
    n_checks++;
    if (stall_armed || err_seen !== 1'b0) begin
      n_fail++; $display("FAIL bp_stall: armed %0b err %b want 0/0", stall_armed, err_seen);
    end
    row = by;
    tick();
    n_checks++;
    if (err_seen !== 1'b1) begin
      n_fail++; $display("FAIL bp_error: got %b want 1", err_seen);
    end
    n_checks++;
    if (!beat || bx != 3 || by != row) begin
      n_fail++; $display("FAIL bp_hold: got beat %0b x %0d y %0d want 1/3/%0d", beat, bx, by, row);
    end
    tick();
    n_checks++;
    if (!beat || bx != 5 || by != row) begin
      n_fail++; $display("FAIL bp_next: got beat %0b x %0d y %0d want 1/5/%0d", beat, bx, by, row);
    end
    n_checks++;
    if (err_seen !== 1'b0) begin
      n_fail++; $display("FAIL bp_pulse_len: got %b want 0", err_seen);
    end
  endtask

  task automatic test_resync();
    int e0;
    bit got;
    shift_line = 2;
    for (int t = 0; t < 400 && g_v == shift_line; t++) tick();
    shift_armed = 1'b1;
    e0 = err_total;
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (err_seen === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || g_h != 15 || g_v != shift_line) begin
      n_fail++; $display("FAIL resync_err: seen %0b gen %0d,%0d want 1 at 15,%0d", got, g_h, g_v,
                         shift_line);
    end
    n_checks++;
    if (obs_locked !== 1'b0) begin
      n_fail++; $display("FAIL resync_unlock: got %b want 0", obs_locked);
    end
    got = 1'b0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (beat) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || bx != 0 || by != 0 || g_h != 2 || g_v != 0) begin
      n_fail++; $display("FAIL resync_resume: got %0d,%0d gen %0d,%0d want 0,0 gen 2,0", bx, by,
                         g_h, g_v);
    end
    n_checks++;
    if (err_total - e0 != 1) begin
      n_fail++; $display("FAIL resync_err_count: got %0d want 1", err_total - e0);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    bit got;
    got = 1'b0;
    for (int t = 0; t < 400; t++) begin
      tick();
      if (beat && bx == 4) begin
        got = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if (!got || obs_valid !== 1'b0 || obs_locked !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: seen %0b valid %b locked %b want 1/0/0", got, obs_valid,
                         obs_locked);
    end
    tick();
    rst_n = 1'b1;
    e0 = err_total;
    got = 1'b0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (beat) begin
        got = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!got || bx != 0 || by != 0 || obs_locked !== 1'b1) begin
      n_fail++; $display("FAIL rst_relock: got %0d,%0d locked %b want 0,0 locked 1", bx, by,
                         obs_locked);
    end
    n_checks++;
    if (err_total != e0) begin
      n_fail++; $display("FAIL rst_relock_err: got %0d want 0", err_total - e0);
    end
  endtask

  task automatic test_blank();
    int e0, drops;
    blank_line = 3;
    for (int t = 0; t < 400 && g_v == blank_line; t++) tick();
    blank_armed = 1'b1;
    e0 = err_total;
    drops = 0;
    for (int t = 0; t < 400 && blank_armed; t++) begin
      tick();
      if (obs_locked !== 1'b1) drops++;
    end
    repeat (4) begin
      tick();
      if (obs_locked !== 1'b1) drops++;
    end
    n_checks++;
    if (err_total - e0 != BlankErrs) begin
      n_fail++; $display("FAIL blank_err: got %0d want %0d", err_total - e0, BlankErrs);
    end
    n_checks++;
    if (drops != 0) begin
      n_fail++; $display("FAIL blank_lock: locked low %0d cycles want 0", drops);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    m_pix_ready  = 1'b1;
    h_visible    = 12'(HV);
    h_sync_start = 12'(HSS);
    h_sync_end   = 12'(HSE);
    h_line_end   = 12'(HLE);
    v_visible    = 12'(VV);
    v_sync_start = 12'(VSS);
    v_sync_end   = 12'(VSE);
    v_frame_end  = 12'(VFE);
    shift_armed  = 1'b0;
    blank_armed  = 1'b0;
    stall_armed  = 1'b0;
    shift_line   = 0;
    blank_line   = 0;
    stall_x      = 0;
    g_h          = 3;
    g_v          = 2;
    drive_pins();
    test_reset();
    test_lock();
    test_full_frame();
    test_backpressure();
    test_resync();
    test_reset_mid();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/svc_vga_pix.md
Name: svc_vga_pix

Overview:
- VGA capture block. Samples a VGA signal set (hsync, vsync, RGB) on the pixel clock and turns it back into a valid/ready pixel stream with x/y coordinates.
- It is the receiving end of svc_pix_vga. Used for loopback verification of the pixel-to-VGA path and for capturing external VGA sources running on the same clock.
- Timing is taken from runtime mode inputs, using the same convention as svc_pix_vga.

Parameters:
- H_WIDTH, 12, width of horizontal counters and timing inputs.
- V_WIDTH, 12, width of vertical counters and timing inputs.
- COLOR_WIDTH, 4, bits per color channel.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  reset (see Behaviour)
- vga_hsync  input  1  horizontal sync, active low
- vga_vsync  input  1  vertical sync, active low
- vga_red / vga_grn / vga_blu  input  COLOR_WIDTH  color inputs
- h_visible / h_sync_start / h_sync_end / h_line_end  input  H_WIDTH  horizontal timing; line_end = last h index
- v_visible / v_sync_start / v_sync_end / v_frame_end  input  V_WIDTH  vertical timing; frame_end = last v index
- m_pix_valid  output  1  pixel valid
- m_pix_red / m_pix_grn / m_pix_blu  output  COLOR_WIDTH  pixel color
- m_pix_x  output  H_WIDTH  pixel column
- m_pix_y  output  V_WIDTH  pixel row
- m_pix_ready  input  1  downstream ready
- locked  output  1  timing lock established
- pix_error  output  1  one-cycle pulse per error event

Behaviour:
- Reset: reset rst_n, synchronous, active-low; clock clk.
  - While reset is asserted: m_pix_valid=0, m_pix_red/grn/blu=0, m_pix_x/y=0, locked=0, pix_error=0, FSM=UNLOCKED, input registers cleared with hsync_q=vsync_q=1.
- Stage 0: all vga_* inputs are registered (hsync_q, vsync_q, rgb_q); previous hsync_q/vsync_q are kept for edge detection.
  - h_cnt/v_cnt hold the coordinate of the sample currently in stage 0.
- Counters:
  - h_cnt increments and wraps h_line_end -> 0.
  - On that wrap, v_cnt increments and wraps v_frame_end -> 0.
  - Arithmetic is modulo width; comparisons are unsigned.
- Events (on stage-0 samples):
  - vfall: vsync_q 1->0. Expected position h=0, v=v_sync_start.
  - hfall: hsync_q 1->0. Expected position h=h_sync_start.
  - hrise: hsync_q 0->1. Expected position h=h_sync_end.
- FSM:
  - UNLOCKED:
    - On vfall: load h_cnt=0, v_cnt=v_sync_start; go to ALIGN.
  - ALIGN:
    - Counters run; no pixels are emitted.
    - hfall at h_cnt==h_sync_start: go to LOCKED, locked=1 from the next cycle.
    - hfall at any other h: go to UNLOCKED, pulse pix_error.
  - LOCKED:
    - Any hfall, hrise or vfall at a mismatched position: go to UNLOCKED, locked=0 next cycle, pulse pix_error.
    - An already-held output pixel stays valid until accepted.
    - Simultaneous mismatches produce a single pulse.
- Pixel emit:
  - Condition: FSM==LOCKED and h_cnt<h_visible and v_cnt<v_visible.
  - Emitted pixel = rgb_q with x=h_cnt, y=v_cnt, loaded into the output register.
  - Latency: pins to m_pix_* is 2 cycles.
- Output register (single entry):
  - Valid is cleared on accept when no new pixel is emitted.
  - Emit while m_pix_valid && !m_pix_ready (overflow): drop the new pixel, pulse pix_error, leave held data unchanged.
  - Emit on the same cycle as accept: load the new pixel, valid stays 1.
- Timing inputs are static while locked; changing them mid-frame is undefined except via reset.
- Reset mid-frame: next cycle returns to the reset state; relock requires a new vfall.

Optional Feature:
- Macro: SVC_VGA_PIX_BLANK_CHECK_EN
- Defined: while LOCKED, any nonzero rgb_q outside the visible region pulses pix_error. Lock is not dropped.
- Undefined: blanking color is ignored; no extra logic is instantiated.

Test Plan:
- Lock: run svc_pix_vga at 640x480 (640/656/752/799, 480/490/492/524) and start this block mid-frame.
  -> locked=0 until vfall, then ALIGN.
  -> locked rises 2 cycles after the hfall at h=656 of line 490.
  -> First beat is (0,0), arriving (525-490)*800 cycles after vfall + 2.
- Full frame: m_pix_ready=1, generator color 2/4/8.
  -> Exactly 307200 beats, raster order x 0..639, y 0..479, all colors 2/4/8, pix_error never 1.
- Backpressure: deassert m_pix_ready for 1 cycle mid-line at x=100.
  -> Pixel x=101 dropped, pix_error high exactly 1 cycle, held beat stays x=100 until accepted.
  -> Next beat is x=102.
- Resync: delay vga_hsync by 3 cycles for one line while locked.
  -> pix_error pulse at the hfall with h=659, locked=0.
  -> Relocks after the next vfall and hfall; pixels resume at (0,0) of the following frame.
- Reset mid-line at x=320: assert rst_n=0 for 2 cycles.
  -> m_pix_valid=0 and locked=0 on the cycle after the first reset edge; normal relock afterwards.
- SVC_VGA_PIX_BLANK_CHECK_EN: drive rgb=4'h1 at h=700 in a locked line.
  -> Define set: pix_error pulses, locked stays 1.
  -> Define clear: no pulse.
